// File: rtl/wb_queue_pkg.sv
// wb_queue_pkg: shared request layout, FSM states and helpers for wb_req_queue
package wb_queue_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_BE_MAX = 128;
  typedef struct packed {
    logic [WB_AW-1:0] addr;
    logic [WB_DW-1:0] data;
    logic [WB_DW/8-1:0] we;
  } wb_req_t;
  typedef enum logic [1:0] {IDLE, BUSY, RESP} wb_state_t;
  function automatic logic is_write(input logic [WB_BE_MAX-1:0] we);
    return |we;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy count; push ignored when full, pop ignored when empty
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic [WIDTH-1:0]             data_i,
  output logic [WIDTH-1:0]             data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0] r_wr, r_rd;
  logic [LW-1:0] r_count;
  logic w_push, w_pop;
  assign full_o  = r_count == LW'(DEPTH);
  assign empty_o = r_count == '0;
  assign count_o = r_count;
  assign data_o  = r_mem[r_rd];
  assign w_push  = push_i & ~full_o;
  assign w_pop   = pop_i & ~empty_o;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      r_wr    <= w_push ? r_wr + 1'b1 : r_wr;
      r_rd    <= w_pop ? r_rd + 1'b1 : r_rd;
      r_count <= r_count + LW'(w_push) - LW'(w_pop);
    end
  end
  always_ff @(posedge clk_i)
    if (w_push) r_mem[r_wr] <= data_i;
endmodule

// File: rtl/wb_req_queue.sv
// wb_req_queue: queues core load/store requests and issues them one at a time to wishbone_master
module wb_req_queue
  import wb_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = WB_AW,
  parameter int DW    = WB_DW
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [AW-1:0]                req_addr_i,
  input  logic [DW-1:0]                req_data_i,
  input  logic [DW/8-1:0]              req_we_i,
  output logic                         resp_valid_o,
  output logic [DW-1:0]                resp_data_o,
  output logic [DW/8-1:0]              resp_we_o,
  output logic [$clog2(DEPTH+1)-1:0]   level_o,
  output logic                         mst_valid_o,
  output logic [AW-1:0]                mst_addr_o,
  output logic [DW-1:0]                mst_data_o,
  output logic [DW/8-1:0]              mst_we_o,
  input  logic                         mst_valid_i,
  input  logic [DW-1:0]                mst_data_i
);
  localparam int BW = DW/8;
  // same field order as wb_req_t, sized to this instance
  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [BW-1:0] we;
  } req_t;
  req_t w_in, w_head, r_mst;
  wb_state_t r_state;
  logic w_full, w_empty, w_pop;
  logic r_mst_valid, r_resp_valid;
  logic [DW-1:0] r_resp_data;
  logic [BW-1:0] r_resp_we;
  assign w_in         = {req_addr_i, req_data_i, req_we_i};
  assign w_pop        = (r_state == IDLE) & ~w_empty;
  assign req_ready_o  = ~w_full;
  assign resp_valid_o = r_resp_valid;
  assign resp_data_o  = r_resp_data;
  assign resp_we_o    = r_resp_we;
  assign mst_valid_o  = r_mst_valid;
  assign mst_addr_o   = r_mst.addr;
  assign mst_data_o   = r_mst.data;
  assign mst_we_o     = r_mst.we;
  sync_fifo #(.WIDTH($bits(req_t)), .DEPTH(DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (req_valid_i),
    .pop_i   (w_pop),
    .data_i  (w_in),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty),
    .count_o (level_o)
  );
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_mst        <= '0;
      r_mst_valid  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_we    <= '0;
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        IDLE: if (!w_empty) begin
          r_mst       <= w_head;
          r_mst_valid <= 1'b1;
          r_state     <= BUSY;
        end
        BUSY: if (mst_valid_i) begin
          r_resp_data  <= is_write(WB_BE_MAX'(r_mst.we)) ? '0 : mst_data_i;
          r_resp_we    <= r_mst.we;
          r_mst_valid  <= 1'b0;
          r_resp_valid <= 1'b1;
          r_state      <= RESP;
        end
        RESP: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_req_queue.sv
// tb_wb_req_queue: vector table plus directed corner sequences, checked through a response scoreboard
module tb_wb_req_queue;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_i;
  logic req_valid_i, req_ready_o, resp_valid_o, mst_valid_o, mst_valid_i;
  logic [31:0] req_addr_i, req_data_i, resp_data_o, mst_addr_o, mst_data_o, mst_data_i;
  logic [3:0] req_we_i, resp_we_o, mst_we_o;
  logic [2:0] level_o;
  always #5 clk = ~clk;
  wb_req_queue #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_we_i(req_we_i),
    .resp_valid_o(resp_valid_o), .resp_data_o(resp_data_o), .resp_we_o(resp_we_o),
    .level_o(level_o),
    .mst_valid_o(mst_valid_o), .mst_addr_o(mst_addr_o), .mst_data_o(mst_data_o), .mst_we_o(mst_we_o),
    .mst_valid_i(mst_valid_i), .mst_data_i(mst_data_i)
  );
  typedef struct {logic [31:0] data; logic [3:0] we;} exp_t;
  typedef struct {logic [31:0] addr; logic [31:0] data; logic [3:0] we; logic [31:0] exp_data;} vec_t;
  exp_t sb[$];
  vec_t vecs[10];
  int n_chk = 0, n_pass = 0, n_resp = 0, r0;
  int lat = 5, wait_cnt = 0, ack_req = 0, ack_done = 0;
  bit auto_ack = 1'b1;
  logic [31:0] slave_mem[8], ref_mem[8], a_v, d_v;
  logic prev_v;
  logic [67:0] prev_cmd;
  exp_t e_v;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // slave side of wishbone_master: completes after lat cycles, or once on request
  initial begin
    mst_valid_i = 1'b0;
    mst_data_i = '0;
    foreach (slave_mem[i]) slave_mem[i] = 32'hDEADBEEF;
    forever begin
      @(negedge clk);
      mst_valid_i = 1'b0;
      if (ack_req != ack_done || (auto_ack && mst_valid_o && wait_cnt == lat-1)) begin
        ack_done = ack_req;
        wait_cnt = 0;
        mst_valid_i = 1'b1;
        mst_data_i = (mst_we_o != 0) ? 32'hBAD0C0DE : slave_mem[mst_addr_o[4:2]];
        if (mst_valid_o && mst_we_o != 0) slave_mem[mst_addr_o[4:2]] = mst_data_o;
      end else if (auto_ack && mst_valid_o) wait_cnt++;
      else wait_cnt = 0;
    end
  end

  initial begin
    prev_v = 1'b0;
    prev_cmd = '0;
    forever begin
      @(negedge clk);
      if (resp_valid_o) begin
        n_resp++;
        if (sb.size() == 0) check("resp_unexpected", 128'(1), 128'(0));
        else begin
          e_v = sb.pop_front();
          check("resp_data", 128'(resp_data_o), 128'(e_v.data));
          check("resp_we", 128'(resp_we_o), 128'(e_v.we));
        end
      end
      if (prev_v && mst_valid_o) check("mst_stable", 128'({mst_addr_o, mst_data_o, mst_we_o}), 128'(prev_cmd));
      prev_v = mst_valid_o;
      prev_cmd = {mst_addr_o, mst_data_o, mst_we_o};
    end
  end

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [3:0] we, input logic [31:0] e);
    int t = 0;
    exp_t x;
    req_valid_i = 1'b1; req_addr_i = a; req_data_i = d; req_we_i = we;
    while (!req_ready_o && t < 300) begin @(negedge clk); t++; end
    x.data = e; x.we = we;
    if (req_ready_o) sb.push_back(x);
    else check("push_timeout", 128'(0), 128'(1));
    @(negedge clk);
    req_valid_i = 1'b0;
  endtask

  task automatic wait_mst();
    int t = 0;
    while (!mst_valid_o && t < 50) begin @(negedge clk); t++; end
    check("mst_valid_rise", 128'(mst_valid_o), 128'(1));
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || mst_valid_o) && t < 500) begin @(negedge clk); t++; end
    check("drain_done", 128'(sb.size()), 128'(0));
    repeat (2) @(negedge clk);
  endtask

  task automatic ack_once();
    @(posedge clk);
    #1 ack_req++;
    @(negedge clk);
  endtask

  initial begin
    rst_i = 1'b1;
    req_valid_i = 1'b0; req_addr_i = '0; req_data_i = '0; req_we_i = '0;
    foreach (ref_mem[i]) ref_mem[i] = 32'hDEADBEEF;
    repeat (3) @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    check("rst_ready", 128'(req_ready_o), 128'(1));
    check("rst_resp_valid", 128'(resp_valid_o), 128'(0));
    check("rst_resp_data", 128'(resp_data_o), 128'(0));
    check("rst_resp_we", 128'(resp_we_o), 128'(0));
    check("rst_level", 128'(level_o), 128'(0));
    check("rst_mst_valid", 128'(mst_valid_o), 128'(0));
    check("rst_mst_cmd", 128'({mst_addr_o, mst_data_o, mst_we_o}), 128'(0));
    // single read, slave answers 5 cycles after issue
    push(32'h04, 32'h0, 4'h0, 32'hDEADBEEF);
    wait_mst();
    check("rd_mst_addr", 128'(mst_addr_o), 128'(32'h04));
    check("rd_mst_we", 128'(mst_we_o), 128'(0));
    drain();
    // single write
    push(32'h08, 32'h12345678, 4'hF, 32'h0);
    ref_mem[2] = 32'h12345678;
    wait_mst();
    check("wr_mst_we", 128'(mst_we_o), 128'(4'hF));
    check("wr_mst_data", 128'(mst_data_o), 128'(32'h12345678));
    drain();
    check("idle_level", 128'(level_o), 128'(0));
    // ordering and pointer wrap: write/read pairs, each read must see its preceding write
    lat = 2;
    for (int k = 0; k < 10; k++) begin
      a_v = ((k/2) * 20) & 32'h1C;
      if (k % 2 == 0) begin
        d_v = $urandom;
        ref_mem[a_v[4:2]] = d_v;
        vecs[k] = '{a_v, d_v, 4'hF, 32'h0};
      end else vecs[k] = '{a_v, 32'h0, 4'h0, ref_mem[a_v[4:2]]};
    end
    r0 = n_resp;
    for (int k = 0; k < 10; k++) push(vecs[k].addr, vecs[k].data, vecs[k].we, vecs[k].exp_data);
    drain();
    check("order_resp_count", 128'(n_resp - r0), 128'(10));
    // fill: one in flight plus DEPTH queued, then a held request must wait
    auto_ack = 1'b0;
    lat = 1;
    for (int k = 0; k < 5; k++) begin
      d_v = 32'hA0 + k;
      ref_mem[k] = d_v;
      push(32'(k * 4), d_v, 4'hF, 32'h0);
    end
    repeat (2) @(negedge clk);
    check("full_level", 128'(level_o), 128'(4));
    check("full_ready", 128'(req_ready_o), 128'(0));
    req_valid_i = 1'b1; req_addr_i = 32'h14; req_data_i = 32'h5555AAAA; req_we_i = 4'hF;
    repeat (3) @(negedge clk);
    check("full_held_level", 128'(level_o), 128'(4));
    auto_ack = 1'b1;
    ref_mem[5] = 32'h5555AAAA;
    push(32'h14, 32'h5555AAAA, 4'hF, 32'h0);
    drain();
    check("fill_level_end", 128'(level_o), 128'(0));
    // simultaneous push and pop at level 2
    auto_ack = 1'b0;
    push(32'h00, 32'h0, 4'h0, ref_mem[0]);
    push(32'h14, 32'h0, 4'h0, ref_mem[5]);
    push(32'h08, 32'h0, 4'h0, ref_mem[2]);
    @(negedge clk);
    check("sim_level_pre", 128'(level_o), 128'(2));
    ack_once();
    @(negedge clk);
    @(negedge clk);
    push(32'h1C, 32'h0, 4'h0, ref_mem[7]);
    check("sim_level_post", 128'(level_o), 128'(2));
    check("sim_mst_addr", 128'(mst_addr_o), 128'(32'h14));
    check("sim_mst_valid", 128'(mst_valid_o), 128'(1));
    auto_ack = 1'b1;
    drain();
    // reset while BUSY with three queued
    auto_ack = 1'b0;
    for (int k = 0; k < 4; k++) push(32'(k * 4), 32'h0, 4'h0, ref_mem[k]);
    @(negedge clk);
    check("rb_level_pre", 128'(level_o), 128'(3));
    check("rb_busy", 128'(mst_valid_o), 128'(1));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0;
    sb.delete();
    check("rb_mst_valid", 128'(mst_valid_o), 128'(0));
    check("rb_level", 128'(level_o), 128'(0));
    check("rb_resp_valid", 128'(resp_valid_o), 128'(0));
    r0 = n_resp;
    ack_once();
    repeat (4) @(negedge clk);
    check("rb_late_ack_resp", 128'(n_resp - r0), 128'(0));
    check("rb_late_ack_mst", 128'(mst_valid_o), 128'(0));
    check("rb_late_ack_level", 128'(level_o), 128'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
